vga_timing_gen: RTL and testbench

//  Consumes the divided pixel-rate strobe from the clock generator and produces VGA

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 96 +++++++++
 tb/tb_vga_timing_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and phase encodings for the VGA raster generator.
// Defaults describe 640x480@60.
package vga_timing_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   =
    VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   =
    VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// wrap is a decode of the current count so the next axis can advance on it.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter int CNT_W   = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ce,
  output logic [CNT_W-1:0] cnt,
  output phase_t           phase,
  output logic             in_sync,
  output logic             active,
  output logic             wrap
);

  localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] F_START = CNT_W'(DISPLAY);
  localparam logic [CNT_W-1:0] S_START = CNT_W'(DISPLAY + FRONT);
  localparam logic [CNT_W-1:0] B_START = CNT_W'(DISPLAY + FRONT + SYNC);

  logic [CNT_W-1:0] nxt;

  assign wrap = (cnt == LAST);
  assign nxt  = wrap ? '0 : cnt + CNT_W'(1);

  // Reset parks the axis on its last count so the first ce lands on 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= LAST;
      phase   <= ST_BACK;
      in_sync <= 1'b0;
      active  <= 1'b0;
    end else if (ce) begin
      cnt <= nxt;
      unique case (phase)
        ST_ACTIVE: if (nxt == F_START) begin
          phase  <= ST_FRONT;
          active <= 1'b0;
        end
        ST_FRONT: if (nxt == S_START) begin
          phase   <= ST_SYNC;
          in_sync <= 1'b1;
        end
        ST_SYNC: if (nxt == B_START) begin
          phase   <= ST_BACK;
          in_sync <= 1'b0;
        end
        ST_BACK: if (wrap) begin
          phase  <= ST_ACTIVE;
          active <= 1'b1;
        end
        default: phase <= ST_BACK;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: two chained axis counters advanced by the pixel strobe,
// with sync polarity applied and line/frame start pulses.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit SYNC_POL  = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  phase_t h_phase;
  phase_t v_phase;
  logic   h_sync_on;
  logic   v_sync_on;
  logic   h_active;
  logic   v_active;
  logic   h_wrap;
  logic   v_wrap;
  logic   v_ce;

  assign v_ce = pix_ce & h_wrap;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .CNT_W  (CNT_W)
  ) u_h (
    .CLK    (CLK),
    .RST    (RST),
    .ce     (pix_ce),
    .cnt    (pixel_x),
    .phase  (h_phase),
    .in_sync(h_sync_on),
    .active (h_active),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .DISPLAY(V_DISPLAY),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .CNT_W  (CNT_W)
  ) u_v (
    .CLK    (CLK),
    .RST    (RST),
    .ce     (v_ce),
    .cnt    (pixel_y),
    .phase  (v_phase),
    .in_sync(v_sync_on),
    .active (v_active),
    .wrap   (v_wrap)
  );

  assign hsync    = h_sync_on ~^ SYNC_POL;
  assign vsync    = v_sync_on ~^ SYNC_POL;
  assign video_on = h_active & v_active;

  logic h_end;
  logic v_end;

  // An axis only leaves its last count from the back porch.
  assign h_end = h_wrap & (h_phase == ST_BACK);
  assign v_end = v_wrap & (v_phase == ST_BACK);

  always_ff @(posedge CLK) begin
    if (RST) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce & h_end;
      frame_start <= pix_ce & h_end & v_end;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance plus a tiny one
// that makes whole-frame wrap and vsync-width checks cheap.
module tb_vga_timing_gen;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic pix_ce = 1'b0;

  always #5 CLK = ~CLK;

  logic       hs0, vs0, vo0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, vo1, ls1, fs1;
  logic [3:0] x1, y1;

  vga_timing_gen dut0 (
    .CLK(CLK), .RST(RST), .pix_ce(pix_ce),
    .hsync(hs0), .vsync(vs0), .video_on(vo0),
    .pixel_x(x0), .pixel_y(y0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b0), .CNT_W(4)
  ) dut1 (
    .CLK(CLK), .RST(RST), .pix_ce(pix_ce),
    .hsync(hs1), .vsync(vs1), .video_on(vo1),
    .pixel_x(x1), .pixel_y(y1),
    .line_start(ls1), .frame_start(fs1)
  );

  // Reference geometry per instance
  int hd[2] = '{640, 8};
  int hf[2] = '{16, 2};
  int hw[2] = '{96, 3};
  int hb[2] = '{48, 2};
  int vd[2] = '{480, 6};
  int vf[2] = '{10, 2};
  int vw[2] = '{2, 2};
  int vb[2] = '{33, 3};

  int mx[2];
  int my[2];
  bit mls[2];
  bit mfs[2];

  int tests = 0;
  int fails = 0;
  bit count_vlow = 0;
  int vlow = 0;

  function automatic logic [24:0] expv(int k);
    int  ht, vt;
    bit  h_in, v_in, on;
    ht = hd[k] + hf[k] + hw[k] + hb[k];
    vt = vd[k] + vf[k] + vw[k] + vb[k];
    h_in = (mx[k] >= hd[k] + hf[k]) && (mx[k] < hd[k] + hf[k] + hw[k]);
    v_in = (my[k] >= vd[k] + vf[k]) && (my[k] < vd[k] + vf[k] + vw[k]);
    on = (mx[k] < hd[k]) && (my[k] < vd[k]);
    if (mx[k] >= ht || my[k] >= vt) on = 1'b0;
    return {!h_in, !v_in, on, 10'(mx[k]), 10'(my[k]), mls[k], mfs[k]};
  endfunction

  function automatic logic [24:0] obsv(int k);
    if (k == 0)
      return {hs0, vs0, vo0, x0, y0, ls0, fs0};
    return {hs1, vs1, vo1, 6'd0, x1, 6'd0, y1, ls1, fs1};
  endfunction

  task automatic chk(input string tag, input logic [24:0] obs,
                     input logic [24:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input bit ce, input bit rst);
    int ht, vt;
    ht = hd[k] + hf[k] + hw[k] + hb[k];
    vt = vd[k] + vf[k] + vw[k] + vb[k];
    if (rst) begin
      mx[k] = ht - 1;
      my[k] = vt - 1;
      mls[k] = 0;
      mfs[k] = 0;
    end else if (ce) begin
      mx[k] = (mx[k] + 1) % ht;
      if (mx[k] == 0) my[k] = (my[k] + 1) % vt;
      mls[k] = (mx[k] == 0);
      mfs[k] = (mx[k] == 0) && (my[k] == 0);
    end else begin
      mls[k] = 0;
      mfs[k] = 0;
    end
  endtask

  task automatic step(input bit ce, input bit rst);
    pix_ce = ce;
    RST = rst;
    @(posedge CLK);
    #1;
    model(0, ce, rst);
    model(1, ce, rst);
    chk("model_big", obsv(0), expv(0));
    chk("model_small", obsv(1), expv(1));
    if (count_vlow && !vs1) vlow++;
  endtask

  initial begin
    logic [24:0] snap;

    // 1: reset then first strobe enters (0,0)
    repeat (3) step(1'b1, 1'b1);
    chk("rst_x", 25'(x0), 25'd799);
    chk("rst_y", 25'(y0), 25'd524);
    chk("rst_flags", 25'({vo0, hs0, vs0, ls0, fs0}), 25'b01100);
    step(1'b1, 1'b0);
    chk("s1_pos", 25'({x0, y0}), 25'd0);
    chk("s1_flags", 25'({vo0, hs0, vs0, ls0, fs0}), 25'b11111);
    step(1'b0, 1'b0);
    chk("s1_pulse_clr", 25'({x0, ls0, fs0}), 25'd0);

    // 2/3: one full line from (0,0)
    repeat (640) step(1'b1, 1'b0);
    chk("s2_vo_fall", 25'({x0, vo0}), 25'({10'd640, 1'b0}));
    repeat (16) step(1'b1, 1'b0);
    chk("s2_hs_low", 25'({x0, hs0}), 25'({10'd656, 1'b0}));
    repeat (96) step(1'b1, 1'b0);
    chk("s2_hs_high", 25'({x0, hs0}), 25'({10'd752, 1'b1}));
    repeat (48) step(1'b1, 1'b0);
    chk("s3_line", 25'({x0, y0, ls0, fs0}), 25'({10'd0, 10'd1, 2'b10}));

    // 4: whole-frame wrap and vsync width on the small instance
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("s4_start", 25'({x1, y1, fs1}), 25'd1);
    count_vlow = 1;
    repeat (195) step(1'b1, 1'b0);
    count_vlow = 0;
    chk("s4_vlow", 25'(vlow), 25'd30);
    chk("s4_wrap", 25'({x1, y1, ls1, fs1}), 25'b11);

    // 5: 1-in-4 strobes, a frozen gap, then random strobes
    for (int i = 0; i < 1203; i++) step(i % 4 == 3, 1'b0);
    snap = obsv(0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0);
      chk("s5_frozen", obsv(0), snap);
    end
    for (int i = 0; i < 600; i++) step($urandom_range(0, 2) == 0, 1'b0);

    // 6: reset mid-line, recovery as after power-up
    for (int i = 0; i < 900 && x0 != 10'd700; i++) step(1'b1, 1'b0);
    chk("s6_reach", 25'(x0), 25'd700);
    step(1'b1, 1'b1);
    chk("s6_rst", 25'({x0, y0, vo0, hs0, vs0, ls0, fs0}),
        25'({10'd799, 10'd524, 5'b01100}));
    step(1'b1, 1'b0);
    chk("s6_recover", 25'({x0, y0, vo0, hs0, vs0, ls0, fs0}),
        25'({20'd0, 5'b11111}));
    repeat (20) step($urandom_range(0, 1) == 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
